qwait_ctrl: RTL and testbench

//  Sequences QWAIT execution in the CC pipeline. Accepts the zero-extended QWAIT

---
 rtl/cc_pkg.sv | 6 +
 rtl/qw_down_cnt.sv | 20 ++
 rtl/qwait_ctrl.sv | 64 ++++++
 tb/tb_qwait_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// cc_pkg: shared CC pipeline types and default widths
package cc_pkg;
  typedef enum logic {QW_IDLE, QW_WAIT} qw_state_t;
  localparam int QW_CNT_W = 20;
  localparam int CC_TS_W = 32;
endpackage

// File: rtl/qw_down_cnt.sv
// qw_down_cnt: loadable down-counter (clr > load > en); ports clk, rst, clr, load, load_val, en, cnt, zero
module qw_down_cnt #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);
  assign zero = cnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/qwait_ctrl.sv
// qwait_ctrl: QWAIT sequencer; ports clk, rst, tick_en, flush, qw_valid, qw_cycles -> qw_ready, qw_done, stall, remain, timeline, ts_wrap
module qwait_ctrl
  import cc_pkg::*;
#(
  parameter int CNT_W = QW_CNT_W,
  parameter int TS_W  = CC_TS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             flush,
  input  logic             qw_valid,
  input  logic [CNT_W-1:0] qw_cycles,
  output logic             qw_ready,
  output logic             qw_done,
  output logic             stall,
  output logic [CNT_W-1:0] remain,
  output logic [TS_W-1:0]  timeline,
  output logic             ts_wrap
);
  qw_state_t state_q, state_d;
  logic accept, in_wait, wait_tick, last, zero, done_d;
  logic [TS_W:0] tl_sum;
  assign accept    = qw_valid & qw_ready;
  assign in_wait   = state_q == QW_WAIT;
  assign wait_tick = in_wait & tick_en & ~flush;
  assign last      = wait_tick & (remain == CNT_W'(1));
  assign done_d    = (accept & (qw_cycles == '0)) | last;
  assign tl_sum    = {1'b0, timeline} + 1'b1;
  qw_down_cnt #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .load(accept),
    .load_val(qw_cycles),
    .en(wait_tick),
    .cnt(remain),
    .zero(zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= QW_IDLE;
    else state_q <= state_d;
  // a WAIT with an already-empty counter is unreachable; zero only guards against lockup
  always_comb
    state_d = flush ? QW_IDLE :
              !in_wait ? ((accept && qw_cycles != '0) ? QW_WAIT : QW_IDLE) :
              (last || zero) ? QW_IDLE : QW_WAIT;
  always_comb begin
    stall    = in_wait;
    qw_ready = ~in_wait & ~flush;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      qw_done  <= 1'b0;
      timeline <= '0;
      ts_wrap  <= 1'b0;
    end else begin
      qw_done <= done_d;
      if (wait_tick) begin
        timeline <= tl_sum[TS_W-1:0];
        if (tl_sum[TS_W]) ts_wrap <= 1'b1;
      end
    end
endmodule

// File: tb/tb_qwait_ctrl.sv
module tb_qwait_ctrl;
  logic clk = 0, rst = 1, tick_en = 0, flush = 0, qw_valid = 0;
  logic [19:0] qw_cycles = '0;
  logic qw_ready, qw_done, stall, ts_wrap;
  logic [19:0] remain;
  logic [31:0] timeline;
  logic s_ready, s_done, s_stall, s_wrap;
  logic [19:0] s_remain;
  logic [3:0] s_timeline;
  int total = 0, bad = 0;
  bit m_busy, m_done, m_wrap;
  int m_rem;
  logic [31:0] m_tl;
  logic rp;

  always #5 clk = ~clk;

  qwait_ctrl dut (.clk(clk), .rst(rst), .tick_en(tick_en), .flush(flush), .qw_valid(qw_valid),
    .qw_cycles(qw_cycles), .qw_ready(qw_ready), .qw_done(qw_done), .stall(stall),
    .remain(remain), .timeline(timeline), .ts_wrap(ts_wrap));

  qwait_ctrl #(.CNT_W(20), .TS_W(4)) dut_s (.clk(clk), .rst(rst), .tick_en(tick_en), .flush(flush),
    .qw_valid(qw_valid), .qw_cycles(qw_cycles), .qw_ready(s_ready), .qw_done(s_done),
    .stall(s_stall), .remain(s_remain), .timeline(s_timeline), .ts_wrap(s_wrap));

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_wrap = 0; m_rem = 0; m_tl = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; qw_valid = 0; flush = 0; tick_en = 0; qw_cycles = '0;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic step(input bit v, input int c, input bit t, input bit f, output logic ready_pre);
    @(negedge clk);
    qw_valid = v; qw_cycles = 20'(c); tick_en = t; flush = f;
    #1 ready_pre = qw_ready;
    @(posedge clk);
    if (f) begin
      m_busy = 0; m_rem = 0; m_done = 0;
    end else if (!m_busy) begin
      m_done = v && c == 0;
      if (v && c != 0) begin m_busy = 1; m_rem = c; end
    end else begin
      m_done = 0;
      if (t) begin
        m_rem--;
        if (m_tl == 32'hFFFF_FFFF) m_wrap = 1;
        m_tl++;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (stall !== 0 || qw_ready !== 1 || remain !== 0 || timeline !== 0 || qw_done !== 0 || ts_wrap !== 0) begin
      bad++; $display("FAIL reset_state: stall=%b ready=%b remain=%0d tl=%0d done=%b wrap=%b want 0 1 0 0 0 0", stall, qw_ready, remain, timeline, qw_done, ts_wrap);
    end
    do_reset();
  endtask

  task automatic test_wait5();
    do_reset();
    step(1, 5, 1, 0, rp);
    total++; if (stall !== 1 || remain !== 5) begin bad++; $display("FAIL wait5_start: stall=%b remain=%0d want 1 5", stall, remain); end
    for (int i = 1; i < 5; i++) begin
      step(0, 0, 1, 0, rp);
      total++; if (stall !== 1 || remain !== 20'(5 - i) || qw_done !== 0) begin
        bad++; $display("FAIL wait5_tick%0d: stall=%b remain=%0d done=%b want 1 %0d 0", i, stall, remain, qw_done, 5 - i);
      end
    end
    step(0, 0, 1, 0, rp);
    total++; if (stall !== 0 || qw_done !== 1 || timeline !== 5 || remain !== 0) begin
      bad++; $display("FAIL wait5_end: stall=%b done=%b tl=%0d remain=%0d want 0 1 5 0", stall, qw_done, timeline, remain);
    end
    step(0, 0, 1, 0, rp);
    total++; if (qw_done !== 0) begin bad++; $display("FAIL wait5_pulse: done=%b want 0", qw_done); end
  endtask

  task automatic test_zero();
    do_reset();
    step(1, 0, 1, 0, rp);
    total++; if (stall !== 0 || qw_done !== 1 || timeline !== 0) begin
      bad++; $display("FAIL zero_single: stall=%b done=%b tl=%0d want 0 1 0", stall, qw_done, timeline);
    end
    step(0, 0, 1, 0, rp);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, rp);
      total++; if (rp !== 1 || qw_done !== 1 || stall !== 0) begin
        bad++; $display("FAIL zero_b2b%0d: ready=%b done=%b stall=%b want 1 1 0", i, rp, qw_done, stall);
      end
    end
    step(0, 0, 1, 0, rp);
    total++; if (qw_done !== 0 || timeline !== 0) begin bad++; $display("FAIL zero_after: done=%b tl=%0d want 0 0", qw_done, timeline); end
  endtask

  task automatic test_tick_pattern();
    bit pat [6] = '{1, 0, 1, 0, 1, 1};
    int highs = 0;
    do_reset();
    step(1, 4, 1, 0, rp);
    for (int i = 0; i < 6; i++) begin
      if (stall === 1) highs++;
      step(0, 0, pat[i], 0, rp);
    end
    total++; if (highs !== 6 || stall !== 0 || qw_done !== 1 || timeline !== 4) begin
      bad++; $display("FAIL tick_pattern: stall_cycles=%0d stall=%b done=%b tl=%0d want 6 0 1 4", highs, stall, qw_done, timeline);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step(1, 10, 1, 0, rp);
    repeat (3) step(0, 0, 1, 0, rp);
    step(1, 7, 0, 1, rp);
    total++; if (rp !== 0) begin bad++; $display("FAIL flush_ready: ready=%b want 0", rp); end
    total++; if (stall !== 0 || remain !== 0 || qw_done !== 0 || timeline !== 3) begin
      bad++; $display("FAIL flush_abort: stall=%b remain=%0d done=%b tl=%0d want 0 0 0 3", stall, remain, qw_done, timeline);
    end
    step(0, 0, 1, 0, rp);
    total++; if (stall !== 0 || qw_done !== 0 || remain !== 0) begin
      bad++; $display("FAIL flush_noaccept: stall=%b done=%b remain=%0d want 0 0 0", stall, qw_done, remain);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(1, 5, 1, 0, rp);
    repeat (2) step(0, 0, 1, 0, rp);
    @(negedge clk);
    rst = 1;
    #1;
    total++; if (stall !== 0 || qw_ready !== 1 || remain !== 0 || timeline !== 0 || qw_done !== 0) begin
      bad++; $display("FAIL mid_reset: stall=%b ready=%b remain=%0d tl=%0d done=%b want 0 1 0 0 0", stall, qw_ready, remain, timeline, qw_done);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    step(1, 7, 1, 0, rp); repeat (7) step(0, 0, 1, 0, rp);
    step(1, 7, 1, 0, rp); repeat (7) step(0, 0, 1, 0, rp);
    total++; if (s_timeline !== 4'hE || s_wrap !== 0) begin
      bad++; $display("FAIL wrap_preload: tl=%0h wrap=%b want e 0", s_timeline, s_wrap);
    end
    step(1, 3, 1, 0, rp); repeat (3) step(0, 0, 1, 0, rp);
    total++; if (s_timeline !== 4'h1 || s_wrap !== 1 || s_done !== 1) begin
      bad++; $display("FAIL wrap_cross: tl=%0h wrap=%b done=%b want 1 1 1", s_timeline, s_wrap, s_done);
    end
    step(1, 2, 1, 0, rp); repeat (2) step(0, 0, 1, 0, rp);
    total++; if (s_timeline !== 4'h3 || s_wrap !== 1) begin
      bad++; $display("FAIL wrap_sticky: tl=%0h wrap=%b want 3 1", s_timeline, s_wrap);
    end
    do_reset();
    total++; if (s_wrap !== 0 || s_timeline !== 0) begin
      bad++; $display("FAIL wrap_clear: tl=%0h wrap=%b want 0 0", s_timeline, s_wrap);
    end
  endtask

  task automatic test_random();
    bit v, t, f, exp_rdy;
    int c;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = $urandom_range(0, 1) == 1;
      c = $urandom_range(0, 6);
      t = $urandom_range(0, 9) < 7;
      f = $urandom_range(0, 19) == 0;
      exp_rdy = !m_busy && !f;
      step(v, c, t, f, rp);
      total++; if (rp !== exp_rdy || stall !== m_busy || remain !== 20'(m_rem) || timeline !== m_tl || qw_done !== m_done || ts_wrap !== m_wrap) begin
        bad++; $display("FAIL random_%0d: ready=%b stall=%b remain=%0d tl=%0d done=%b wrap=%b want %b %b %0d %0d %b %b",
          i, rp, stall, remain, timeline, qw_done, ts_wrap, exp_rdy, m_busy, m_rem, m_tl, m_done, m_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wait5();
    test_zero();
    test_tick_pattern();
    test_flush();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
